udp_tx_scheduler: RTL
=====================

// Module: udp_tx_scheduler
// PURPOSE
//  Frame-launch controller for the GMII UDP sender. Shares the single sender
//  between two channel FIFOs using round-robin arbitration, and picks each
//  frame's payload size. Full frames launch on a fill threshold; partial
//  frames are flushed on a per-channel age timeout. Drives the length fields,
//  the FIFO select and a start pulse, then enforces the inter-frame gap.
// PARAMETERS
//  PAYLOAD_BYTES   1000   full-frame UDP payload, bytes (>= MIN_PAYLOAD)
//  MIN_PAYLOAD     18     smallest flushable payload (keeps frame >= 64 B)
//  TIMEOUT_CYCLES  50000  channel age that forces a partial-frame flush
//  IFG_CYCLES      12     idle cycles after sender drops busy
//  ACK_CYCLES      64     max wait for busy after start pulse
// PORTS
//  clk              in   1   GMII transmit clock, rising edge
//  rst              in   1   synchronous reset, active high
//  enable           in   1   0: no new grants; frame in flight completes
//  ch0_count        in   11  channel-0 FIFO occupancy, bytes
//  ch1_count        in   11  channel-1 FIFO occupancy, bytes
//  tx_busy          in   1   sender active (high from first preamble to last CRC byte)
//  tx_start         out  1   one-cycle launch pulse to sender
//  ch_sel           out  1   FIFO/read-enable mux select: 0=ch0, 1=ch1
//  tx_data_length   out  16  UDP length = payload + 8
//  tx_total_length  out  16  IP total length = payload + 28
//  frame_count      out  16  frames completed, wraps 0xFFFF->0
//  ack_err          out  1   sticky: sender never raised busy
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; rr pointer=1 (ch0 wins first); age timers=0.
//  Eligibility, per channel c:
//   - full_c = count_c >= PAYLOAD_BYTES
//   - to_c   = age_c >= TIMEOUT_CYCLES && count_c >= MIN_PAYLOAD
//   - elig_c = full_c | to_c
//  Age timer: resets when count_c==0 or when c is granted. Otherwise
//   increments each cycle, saturating at TIMEOUT_CYCLES.
//  Arbitration: one eligible channel -> that channel. Both eligible -> the
//   channel != rr pointer. The pointer updates to the granted channel.
//  Payload at grant: PAYLOAD_BYTES if full_c, else count_c. Latched at grant.
//   The length outputs are 16-bit unsigned adds of the latched payload. They,
//   and ch_sel, are held from grant until the GAP state exits.
//  FSM:
//   - IDLE: enable && (elig0|elig1) -> GRANT.
//   - GRANT: latch ch_sel, payload and lengths -> LAUNCH.
//     (Lengths are stable >= 1 cycle before tx_start.)
//   - LAUNCH: tx_start=1 for exactly one cycle -> WAIT_ACK; ack counter=0.
//   - WAIT_ACK:
//     - tx_busy -> WAIT_DONE.
//     - ack counter reaching ACK_CYCLES -> set ack_err, -> GAP; frame_count
//       is not incremented.
//   - WAIT_DONE: on tx_busy falling -> GAP; frame_count++ in the same cycle.
//   - GAP: count IFG_CYCLES cycles with tx_busy low -> IDLE.
//     If tx_busy rises during GAP, the gap counter restarts.
//  Latency: eligible in IDLE -> tx_start asserted 2 cycles later.
//   Back-to-back frames: >= IFG_CYCLES+3 cycles from busy fall to next start.
//  enable dropped mid-frame: the frame finishes normally; no new grant until
//   enable=1. Eligibility is evaluated only in IDLE.
//  A channel count decreasing below threshold after grant does not abort.
//  tx_start is never reasserted while tx_busy=1.
//  rst mid-frame: return to IDLE next edge; tx_start=0, ch_sel=0, lengths=0.
//   ack_err and frame_count clear. The sender may still be busy; the first new
//   grant waits until tx_busy is low (IDLE also requires !tx_busy).
// TESTING
//  1. ch0_count=1000, ch1_count=0 -> tx_start 2 cycles later; ch_sel=0;
//     lengths 1008/1028. Model busy 1100 cycles -> frame_count=1 and the next
//     start >= 15 cycles after busy falls.
//  2. Both counts held at 1000 for 4 frames -> ch_sel sequence 0,1,0,1.
//  3. ch1_count=100 held, TIMEOUT_CYCLES=200 -> grant ch1 at age 200;
//     lengths 108/128. With ch1_count=10 -> no grant ever.
//  4. Start issued, busy never rises -> ack_err=1 after 64 cycles;
//     frame_count unchanged; FSM passes through GAP to IDLE.
//  5. enable=0 during WAIT_DONE with ch0 eligible -> frame completes, no new
//     start; enable=1 -> start 2 cycles later.
//  6. rst pulsed in WAIT_DONE with busy still high -> outputs 0 next cycle;
//     no tx_start until busy falls.

Source files
------------

// File: rtl/udp_tx_scheduler.sv
// Frame-launch controller for the GMII UDP sender: round-robin between two
// channel FIFOs, picks payload size, pulses start and enforces the inter-frame gap.
module udp_tx_scheduler #(
    parameter int PAYLOAD_BYTES  = 1000,
    parameter int MIN_PAYLOAD    = 18,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int IFG_CYCLES     = 12,
    parameter int ACK_CYCLES     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [10:0] ch0_count,
    input  logic [10:0] ch1_count,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic        ch_sel,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    output logic [15:0] frame_count,
    output logic        ack_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GRANT     = 3'd1;
    localparam logic [2:0] S_LAUNCH    = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;

    localparam int AW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ACW = $clog2(ACK_CYCLES + 1);
    localparam int GW  = $clog2(IFG_CYCLES + 1);

    localparam logic [10:0]    FULL_TH  = 11'(PAYLOAD_BYTES);
    localparam logic [10:0]    MIN_TH   = 11'(MIN_PAYLOAD);
    localparam logic [AW-1:0]  AGE_MAX  = AW'(TIMEOUT_CYCLES);
    localparam logic [ACW-1:0] ACK_LAST = ACW'(ACK_CYCLES - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'(IFG_CYCLES - 1);

    logic [2:0]     state;
    logic           rr_ptr;
    logic [AW-1:0]  age0, age1;
    logic [ACW-1:0] ack_cnt;
    logic [GW-1:0]  gap_cnt;

    logic        full0, full1, elig0, elig1;
    logic        grant_fire, grant_ch, grant_full;
    logic [10:0] grant_count;
    logic [15:0] payload;

    always_comb begin
        full0 = ch0_count >= FULL_TH;
        full1 = ch1_count >= FULL_TH;
        elig0 = full0 | ((age0 >= AGE_MAX) && (ch0_count >= MIN_TH));
        elig1 = full1 | ((age1 >= AGE_MAX) && (ch1_count >= MIN_TH));
        // Both eligible: the channel not served last time wins.
        grant_ch    = (elig0 && elig1) ? ~rr_ptr : elig1;
        grant_fire  = (state == S_IDLE) && enable && !tx_busy && (elig0 || elig1);
        grant_full  = grant_ch ? full1 : full0;
        grant_count = grant_ch ? ch1_count : ch0_count;
        payload     = grant_full ? 16'(PAYLOAD_BYTES) : {5'd0, grant_count};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age0 <= '0;
            age1 <= '0;
        end else begin
            if (ch0_count == '0 || (grant_fire && !grant_ch))
                age0 <= '0;
            else if (age0 != AGE_MAX)
                age0 <= age0 + 1'b1;
            if (ch1_count == '0 || (grant_fire && grant_ch))
                age1 <= '0;
            else if (age1 != AGE_MAX)
                age1 <= age1 + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            tx_start        <= 1'b0;
            ch_sel          <= 1'b0;
            tx_data_length  <= '0;
            tx_total_length <= '0;
            frame_count     <= '0;
            ack_err         <= 1'b0;
            rr_ptr          <= 1'b1;
            ack_cnt         <= '0;
            gap_cnt         <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Lengths are latched on the grant edge so they settle a cycle ahead of tx_start.
                    if (grant_fire) begin
                        state           <= S_GRANT;
                        ch_sel          <= grant_ch;
                        rr_ptr          <= grant_ch;
                        tx_data_length  <= payload + 16'd8;
                        tx_total_length <= payload + 16'd28;
                    end
                end
                S_GRANT: begin
                    state    <= S_LAUNCH;
                    tx_start <= 1'b1;
                end
                S_LAUNCH: begin
                    state   <= S_WAIT_ACK;
                    ack_cnt <= '0;
                end
                S_WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        ack_err <= 1'b1;
                        state   <= S_GAP;
                        gap_cnt <= '0;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state       <= S_GAP;
                        gap_cnt     <= '0;
                        frame_count <= frame_count + 16'd1;
                    end
                end
                S_GAP: begin
                    if (tx_busy) begin
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state           <= S_IDLE;
                        ch_sel          <= 1'b0;
                        tx_data_length  <= '0;
                        tx_total_length <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
